// File: rtl/des_entry_pkg.sv
// Shared constants and FSM encoding for the hex digit entry buffer feeding the DES stage.
package des_entry_pkg;

    localparam int NIBBLE_COUNT = 16;
    localparam int COUNT_W      = 5;
    localparam int BLOCK_W      = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } entry_state_t;

endpackage

// File: rtl/button_conditioner.sv
// One active-low push button: 2-flop synchronizer, optional debounce (KEYPAD_DEBOUNCE_EN),
// and a falling-edge press pulse decoded only from registers.
module button_conditioner
`ifdef KEYPAD_DEBOUNCE_EN
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    logic       s1_reg;
    logic       s2_reg;
    logic       prev_reg;
    logic       armed_reg;
    logic [1:0] fill_reg;
    logic       level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= 1'b1;
            s2_reg   <= 1'b1;
            fill_reg <= 2'b00;
        end else begin
            s1_reg   <= btn_n;
            s2_reg   <= s1_reg;
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    // Presses are only honoured once a genuinely sampled released level has been seen,
    // so a button held through reset cannot fire on release of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg <= 1'b0;
        end else if (fill_reg[1] && s2_reg) begin
            armed_reg <= 1'b1;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    logic        level_reg;
    logic [19:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b1;
            cnt_reg   <= 20'd0;
        end else if (s2_reg == level_reg) begin
            cnt_reg <= 20'd0;
        end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
            level_reg <= s2_reg;
            cnt_reg   <= 20'd0;
        end else begin
            cnt_reg <= cnt_reg + 20'd1;
        end
    end

    assign level = level_reg;
`else
    assign level = s2_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= level;
        end
    end

    assign press = armed_reg & prev_reg & ~level;

endmodule

// File: rtl/hex_entry_buffer.sv
// Collects up to 16 hex digits from switches and three buttons into a 64-bit block.
// Build with KEYPAD_DEBOUNCE_EN defined to debounce the buttons for DEBOUNCE_CYCLES cycles.
module hex_entry_buffer
    import des_entry_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
)(
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [3:0]         iNIBBLE,
    input  logic               iLOAD_N,
    input  logic               iBACK_N,
    input  logic               iCLEAR_N,
    output logic [BLOCK_W-1:0] oVALUE,
    output logic [COUNT_W-1:0] oCOUNT,
    output logic               oFULL,
    output logic               oCHANGED
);

    localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(NIBBLE_COUNT - 1);

    logic               load_press;
    logic               back_press;
    logic               clear_press;
    logic [3:0]         nib_s1_reg;
    logic [3:0]         nib_s2_reg;
    entry_state_t       state_reg;
    entry_state_t       state_next;
    logic [COUNT_W-1:0] count_reg;
    logic [3:0]         digit_reg [NIBBLE_COUNT];
    logic               changed_reg;
    logic               do_clear;
    logic               do_back;
    logic               do_load;

    // The length only matters when the debounce stage is built in.
    if (DEBOUNCE_CYCLES == 20'd0) begin : g_debounce_zero
    end

`ifdef KEYPAD_DEBOUNCE_EN
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load  (.clk(iCLK), .rst_n(iRST_N), .btn_n(iLOAD_N),  .press(load_press));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back  (.clk(iCLK), .rst_n(iRST_N), .btn_n(iBACK_N),  .press(back_press));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (.clk(iCLK), .rst_n(iRST_N), .btn_n(iCLEAR_N), .press(clear_press));
`else
    button_conditioner u_load  (.clk(iCLK), .rst_n(iRST_N), .btn_n(iLOAD_N),  .press(load_press));
    button_conditioner u_back  (.clk(iCLK), .rst_n(iRST_N), .btn_n(iBACK_N),  .press(back_press));
    button_conditioner u_clear (.clk(iCLK), .rst_n(iRST_N), .btn_n(iCLEAR_N), .press(clear_press));
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            nib_s1_reg <= 4'h0;
            nib_s2_reg <= 4'h0;
        end else begin
            nib_s1_reg <= iNIBBLE;
            nib_s2_reg <= nib_s1_reg;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (do_clear) begin
            state_next = EMPTY;
        end else if (do_back) begin
            state_next = (count_reg == COUNT_W'(1)) ? EMPTY : PARTIAL;
        end else if (do_load) begin
            state_next = (count_reg == LAST_SLOT) ? FULL : PARTIAL;
        end
    end

    // Priority is over raw presses: a backspace that arrives with a load wins even when EMPTY.
    always_comb begin
        do_clear = clear_press;
        do_back  = 1'b0;
        do_load  = 1'b0;
        if (!clear_press) begin
            if (back_press) begin
                do_back = (state_reg != EMPTY);
            end else if (load_press) begin
                do_load = (state_reg != FULL);
            end
        end
        oFULL = (state_reg == FULL);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            count_reg   <= '0;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= do_clear | do_back | do_load;
            if (do_clear) begin
                count_reg <= '0;
            end else if (do_back) begin
                count_reg <= count_reg - COUNT_W'(1);
            end else if (do_load) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NIBBLE_COUNT; gi++) begin : g_digit
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                digit_reg[gi] <= 4'h0;
            end else if (do_clear) begin
                digit_reg[gi] <= 4'h0;
            end else if (do_back && count_reg == COUNT_W'(gi + 1)) begin
                digit_reg[gi] <= 4'h0;
            end else if (do_load && count_reg == COUNT_W'(gi)) begin
                digit_reg[gi] <= nib_s2_reg;
            end
        end
        assign oVALUE[BLOCK_W - 1 - 4 * gi -: 4] = digit_reg[gi];
    end

    assign oCOUNT   = count_reg;
    assign oCHANGED = changed_reg;

endmodule
